// File: rtl/pkt_rx_assembler_if.sv
// Bus between the UART byte source, pkt_rx_assembler and the register bank.
// master: the byte source / register-bank side; slave: the assembler itself.
// IDX_W must match the IDX_W of the assembler that connects to it.
interface pkt_rx_assembler_if #(
  parameter int IDX_W = 6
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic [7:0]       wr_data;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             pkt_done;
  logic             pkt_err;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  wr_data, wr_idx, wr_en, pkt_done, pkt_err, busy
  );

  modport slave (
    input  in_data, in_valid,
    output wr_data, wr_idx, wr_en, pkt_done, pkt_err, busy
  );
endinterface

// File: rtl/pkt_rx_assembler.sv
// pkt_rx_assembler: hunts for SYNC_BYTE in a UART byte stream, then writes
// PKT_LEN payload bytes out with an index and a write strobe, and ends the
// packet with a one-cycle pkt_done or pkt_err pulse. A packet is abandoned
// with pkt_err when no byte arrives for TIMEOUT_CYC cycles (0 = never).
// Optional feature macro: PKT_CHECKSUM_EN -- when defined, one trailing
// checksum byte follows the payload and the packet only passes if the
// payload sum plus that byte is 8'h00 (mod 256).
module pkt_rx_assembler #(
  parameter int          PKT_LEN     = 55,
  parameter int          IDX_W       = 6,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               reset,
  pkt_rx_assembler_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(PKT_LEN - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0]      TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD
`ifdef PKT_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      timer_q, timer_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       csum_total;
`endif
  logic [7:0]       wr_data_q, wr_data_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_en_q, wr_en_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_err_q, pkt_err_d;
  logic             busy_q, busy_d;
  logic             timeout_hit;

  // An idle cycle on the last allowed count abandons the packet; a byte in
  // that same cycle takes priority because the branches below test in_valid first.
  assign timeout_hit = TIMEOUT_EN && (timer_q == TIMEOUT_LAST);

`ifdef PKT_CHECKSUM_EN
  assign csum_total = csum_q + bus.in_data;
`endif

  // Next-state and next-output logic for the sync / payload / check sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
`ifdef PKT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    wr_data_d  = wr_data_q;
    wr_idx_d   = wr_idx_q;
    wr_en_d    = 1'b0;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && (bus.in_data == SYNC_BYTE)) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          timer_d = '0;
`ifdef PKT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_PAYLOAD: begin
        if (bus.in_valid) begin
          wr_data_d = bus.in_data;
          wr_idx_d  = cnt_q;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q + IDX_W'(1);
          timer_d   = '0;
`ifdef PKT_CHECKSUM_EN
          csum_d    = csum_total;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef PKT_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d    = ST_IDLE;
            pkt_done_d = 1'b1;
`endif
          end
        end else if (timeout_hit) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
          timer_d   = '0;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + 32'd1;
        end
      end

`ifdef PKT_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.in_valid) begin
          state_d = ST_IDLE;
          timer_d = '0;
          if (csum_total == 8'h00) begin
            pkt_done_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          pkt_err_d = 1'b1;
          state_d   = ST_IDLE;
          timer_d   = '0;
        end else if (TIMEOUT_EN) begin
          timer_d = timer_q + 32'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any partial packet silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= '0;
`endif
      wr_data_q  <= '0;
      wr_idx_q   <= '0;
      wr_en_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      wr_data_q  <= wr_data_d;
      wr_idx_q   <= wr_idx_d;
      wr_en_q    <= wr_en_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.wr_data  = wr_data_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.pkt_err  = pkt_err_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/pkt_rx_assembler.md
# pkt_rx_assembler

Parametrised byte-stream packet assembler between the UART receiver and the register/config bank. Hunts for a sync byte, writes a fixed-length payload out byte-by-byte with an index and write strobe, then emits a one-cycle packet-complete or packet-error pulse. It generalises the fixed 55-byte loader by adding:
- configurable length and sync byte;
- inter-byte timeout;
- optional checksum.

## Interface
- PKT_LEN, 55, payload bytes per packet (1..2^IDX_W).
- IDX_W, 6, width of wr_idx; 2^IDX_W >= PKT_LEN required.
- SYNC_BYTE, 8'hA5, header value that starts a packet.
- TIMEOUT_CYC, 50000, max idle cycles between accepted bytes inside a packet. 0 disables the timeout.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_data  in  8  received byte, valid when in_valid=1
- in_valid  in  1  one-cycle strobe per received byte (UART rx_done_tick); back-to-back allowed
- wr_data  out  8  payload byte for register bank
- wr_idx  out  IDX_W  payload index 0..PKT_LEN-1
- wr_en  out  1  one-cycle write strobe for wr_data/wr_idx
- pkt_done  out  1  one-cycle pulse: packet accepted
- pkt_err  out  1  one-cycle pulse: packet aborted (timeout or checksum mismatch)
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, PAYLOAD, CHECK (CHECK exists only with PKT_CHECKSUM_EN).
- IDLE:
  - in_valid with in_data==SYNC_BYTE -> PAYLOAD; cnt=0, csum=0, timer=0.
  - Any other byte is ignored.
  - The sync byte is never written.
- PAYLOAD, on in_valid:
  - wr_data<=in_data, wr_idx<=cnt, wr_en<=1.
  - csum<=csum+in_data (mod 256); cnt++; timer=0.
  - On the byte with cnt==PKT_LEN-1: -> CHECK if checksum enabled; otherwise pkt_done<=1 and -> IDLE.
- CHECK, on in_valid:
  - If (csum+in_data) mod 256 == 8'h00: pkt_done<=1, otherwise pkt_err<=1.
  - -> IDLE in both cases. The checksum byte is not written.
- Timeout (PAYLOAD/CHECK only, TIMEOUT_CYC>0):
  - timer increments each cycle without in_valid.
  - When timer==TIMEOUT_CYC-1 with no in_valid: pkt_err<=1, -> IDLE.
  - in_valid in that same cycle wins: the byte is accepted and the timer cleared.
- Writes already issued are never retracted. The consumer discards the shadow copy on pkt_err and commits on pkt_done.
- A sync-valued byte inside PAYLOAD is ordinary payload (no resync).
- wr_en, pkt_done and pkt_err default to 0 every cycle unless set above.
- wr_data and wr_idx hold their last value.

## Timing
- All outputs are registered.
- Reset values: wr_data=0, wr_idx=0, wr_en=0, pkt_done=0, pkt_err=0, busy=0. State=IDLE; cnt, csum and timer are 0.
- Reset mid-packet: the partial packet is dropped and no pulse is emitted.
- in_valid at cycle N gives wr_en at N+1.
- Without checksum: the last payload byte's wr_en and pkt_done are both high at N+1.
- With checksum: pkt_done/pkt_err is high at M+1, where M is the checksum byte's in_valid cycle.
- Block is in IDLE from the cycle after the final byte, so a SYNC_BYTE arriving at N+1 (or M+1) starts the next packet with no dead cycle.
- Timeout pulse occurs TIMEOUT_CYC cycles after the last accepted byte; busy falls in the same cycle.
- timer is 32 bits; cnt is IDX_W bits, compared against PKT_LEN-1 (no wrap).

## Configuration
- Macro: PKT_CHECKSUM_EN.
- Defined:
  - CHECK state present; one trailing checksum byte is expected after the payload.
  - Pass condition: payload sum + checksum == 8'h00 (mod 256).
- Undefined:
  - No CHECK state, no csum register.
  - pkt_done coincides with the last wr_en; pkt_err comes only from timeout.

## Test plan
Bench configuration: PKT_LEN=4, IDX_W=2, TIMEOUT_CYC=20.
- Noise then packet, no checksum: feed 00, 7F, A5, 01, 02, 03, 04 -> 00 and 7F ignored; wr_en x4 with idx 0..3 and data 01..04; pkt_done coincident with the idx=3 write.
- Checksum pass (PKT_CHECKSUM_EN): feed A5, 01, 02, 03, 04, F6 -> four writes, then pkt_done one cycle after F6; no write for F6.
- Checksum fail: same packet with checksum F5 -> pkt_err one cycle after F5; pkt_done stays 0.
- Timeout: feed A5, 01, 02, then idle 20 cycles -> pkt_err 20 cycles after 02; busy drops; the next A5 restarts at idx 0.
- Back-to-back packets on consecutive cycles: in_valid every clk with A5, 11, 22, 33, 44, A5, 55, 66, 77, 88 -> two pkt_done pulses; second packet writes idx 0..3 with data 55..88.
- Reset mid-packet: assert reset after A5, 01 -> all outputs 0 next cycle and no pulse; a fresh packet then completes normally.
